// File: rtl/int_to_fp_collect.sv
// int_to_fp_collect
//   Output collection FIFO that sits after the per-lane int_to_fp converters.
//   Each accepted group is packed on capture. Each lane keeps the low 32 bits
//   of its 64-bit result, and inactive lanes are zeroed. The flags of the
//   active lanes are ORed together. The group is then queued with its control
//   fields until the writeback arbiter takes it.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   in_valid_i/ready_o input handshake (one lane group per push)
//   in_result_i        SOFT_THREAD x 64-bit lane results
//   in_fflags_i        SOFT_THREAD x 5-bit lane exception flags
//   ctrl_*_i           control fields of the group, stored unmodified
//   out_valid_o/ready_i output handshake
//   out_result_o       SOFT_THREAD x 32-bit packed results of the head entry
//   out_fflags_o       merged flags of the head entry
//   ctrl_*_o           control fields of the head entry
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready_o and out_valid_o depend only on registered state.
// So a full buffer refuses a push even in a cycle where it also pops.
module int_to_fp_collect #(
  parameter int SOFT_THREAD  = 4,
  parameter int DEPTH        = 2,
  parameter int REGIDX_WIDTH = 5,
  parameter int REGEXT_WIDTH = 2,
  parameter int DEPTH_WARP   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [64*SOFT_THREAD-1:0]            in_result_i,
  input  logic [5*SOFT_THREAD-1:0]             in_fflags_i,
  input  logic [REGIDX_WIDTH+REGEXT_WIDTH-1:0] ctrl_regindex_i,
  input  logic [DEPTH_WARP-1:0]                ctrl_warpid_i,
  input  logic [SOFT_THREAD-1:0]               ctrl_vecmask_i,
  input  logic                                 ctrl_wvd_i,
  input  logic                                 ctrl_wxd_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [32*SOFT_THREAD-1:0]            out_result_o,
  output logic [4:0]                           out_fflags_o,
  output logic [REGIDX_WIDTH+REGEXT_WIDTH-1:0] ctrl_regindex_o,
  output logic [DEPTH_WARP-1:0]                ctrl_warpid_o,
  output logic [SOFT_THREAD-1:0]               ctrl_vecmask_o,
  output logic                                 ctrl_wvd_o,
  output logic                                 ctrl_wxd_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = REGIDX_WIDTH + REGEXT_WIDTH;

  logic [32*SOFT_THREAD-1:0] result_mem   [DEPTH];
  logic [4:0]                fflags_mem   [DEPTH];
  logic [RW-1:0]             regindex_mem [DEPTH];
  logic [DEPTH_WARP-1:0]     warpid_mem   [DEPTH];
  logic [SOFT_THREAD-1:0]    vecmask_mem  [DEPTH];
  logic                      wvd_mem      [DEPTH];
  logic                      wxd_mem      [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic push;
  logic pop;

  logic [32*SOFT_THREAD-1:0] packed_result;
  logic [4:0]                merged_fflags;
  // The converters' upper 32 bits per lane are never stored.
  logic [32*SOFT_THREAD-1:0] unused_hi_bits;

  assign in_ready_o  = (count != CW'(DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    packed_result  = '0;
    merged_fflags  = '0;
    unused_hi_bits = '0;
    for (int i = 0; i < SOFT_THREAD; i++) begin
      if (ctrl_vecmask_i[i]) begin
        packed_result[32*i +: 32] = in_result_i[64*i +: 32];
        merged_fflags             = merged_fflags | in_fflags_i[5*i +: 5];
      end
      unused_hi_bits[32*i +: 32] = in_result_i[64*i+32 +: 32];
    end
  end

  // The pointers wrap explicitly so that non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) ptr_next = '0;
    else                     ptr_next = p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        result_mem[e]   <= '0;
        fflags_mem[e]   <= '0;
        regindex_mem[e] <= '0;
        warpid_mem[e]   <= '0;
        vecmask_mem[e]  <= '0;
        wvd_mem[e]      <= 1'b0;
        wxd_mem[e]      <= 1'b0;
      end
    end else begin
      if (push) begin
        result_mem[wr_ptr]   <= packed_result;
        fflags_mem[wr_ptr]   <= merged_fflags;
        regindex_mem[wr_ptr] <= ctrl_regindex_i;
        warpid_mem[wr_ptr]   <= ctrl_warpid_i;
        vecmask_mem[wr_ptr]  <= ctrl_vecmask_i;
        wvd_mem[wr_ptr]      <= ctrl_wvd_i;
        wxd_mem[wr_ptr]      <= ctrl_wxd_i;
        wr_ptr               <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // After reset every entry is zero, so the outputs read as zero until the first push.
  assign out_result_o    = result_mem[rd_ptr];
  assign out_fflags_o    = fflags_mem[rd_ptr];
  assign ctrl_regindex_o = regindex_mem[rd_ptr];
  assign ctrl_warpid_o   = warpid_mem[rd_ptr];
  assign ctrl_vecmask_o  = vecmask_mem[rd_ptr];
  assign ctrl_wvd_o      = wvd_mem[rd_ptr];
  assign ctrl_wxd_o      = wxd_mem[rd_ptr];

endmodule

// File: doc/int_to_fp_collect.md
# int_to_fp_collect

Output collection buffer placed directly downstream of the SOFT_THREAD per-lane `int_to_fp` converters in the FPU pipeline. It accepts one lockstep group of lane results per handshake, together with that group's control fields. At capture it packs the 32-bit single-precision results, zeroes inactive lanes, and merges the exception flags of active lanes. It holds up to DEPTH groups in a FIFO and presents them to the FPU writeback arbiter under a valid/ready handshake.

## Interface
Reset is synchronous and active-high; the clock is `clk`, the reset is `rst`.

- SOFT_THREAD, 4, number of lanes per group.
- DEPTH, 2, number of FIFO entries. Legal range is 2..8.
- Widths `REGIDX_WIDTH`, `REGEXT_WIDTH` and `DEPTH_WARP` come from `define.v`.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  group valid, driven by the converter `out_valid_o`.
- in_ready_o  out  1  buffer can accept a group.
- in_result_i  in  64*SOFT_THREAD  lane i result at [64i+63:64i].
- in_fflags_i  in  5*SOFT_THREAD  lane i flags at [5i+4:5i].
- ctrl_regindex_i  in  REGIDX_WIDTH+REGEXT_WIDTH  destination register.
- ctrl_warpid_i  in  DEPTH_WARP  warp id.
- ctrl_vecmask_i  in  SOFT_THREAD  active-lane mask.
- ctrl_wvd_i  in  1  vector register write.
- ctrl_wxd_i  in  1  scalar register write.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  writeback accepts.
- out_result_o  out  32*SOFT_THREAD  packed lane results.
- out_fflags_o  out  5  OR of the flags of active lanes.
- ctrl_regindex_o, ctrl_warpid_o, ctrl_vecmask_o, ctrl_wvd_o, ctrl_wxd_o  out  widths as the inputs  head entry control fields.

## Operation
- Push occurs when `in_valid_i && in_ready_o`. Pop occurs when `out_valid_o && out_ready_i`.
- Packing at push, for each lane i:
  - If `vecmask[i]`=1, the entry lane field is `in_result_i[64i+31:64i]`.
  - If `vecmask[i]`=0, the entry lane field is 0.
- Flag merge at push: the entry flags are the bitwise OR of `in_fflags_i` lanes with `vecmask[i]`=1. A mask of all zeros gives flags 0.
- Control fields are stored unmodified alongside the data.
- State consists of:
  - a write pointer and a read pointer, each wrapping modulo DEPTH (DEPTH=3 must also wrap correctly, so do not rely on power-of-two overflow);
  - a count register of width clog2(DEPTH+1).
- Counter update:
  - push only: count+1;
  - pop only: count-1;
  - push and pop together: count unchanged, and both pointers advance.
- `in_ready_o` = (count != DEPTH), decoded from registered state only. There is no combinational path from `out_ready_i` to `in_ready_o`, so a full buffer refuses a push even when a pop happens in the same cycle.
- `out_valid_o` = (count != 0).
- All out data is read from the entry at the read pointer. It holds stable while `out_valid_o`=1 and `out_ready_i`=0.
- Invariants:
  - Count never exceeds DEPTH and never underflows.
  - A pop with count 0 is impossible by construction.
  - `in_valid_i` while full is a legal stall; the input is not captured.
- Reset:
  - Pointers and count are set to 0.
  - All storage entries are set to 0.
  - `out_valid_o`=0, `in_ready_o`=1, and all out data and ctrl outputs are 0.
- Reset asserted mid-operation discards all held groups at that clock edge; no pop is reported for them. A push presented in the same cycle as reset is dropped.

## Timing
- Latency from push to `out_valid_o` is 1 cycle, since entries are written at the clock edge. There is no bypass.
- Throughput is 1 group per cycle sustained when `out_ready_i`=1 continuously (DEPTH≥2).
- With `out_ready_i` stuck at 0, exactly DEPTH groups are accepted. `in_ready_o` falls in the cycle after the DEPTH-th push, and rises in the cycle after the first pop.
- Output ordering is strictly FIFO.

## Test plan
- Single push after reset:
  - Stimulus: lane0 result 0x00000000_3F800000, lanes1-3 0x…_40000000, vecmask 4'b1011, fflags lane0=5'b00001 and lane2=5'b10000.
  - Response: one cycle later `out_valid_o`=1, out_result = {0x40000000, 0x00000000, 0x40000000, 0x3F800000} (lane3..lane0), out_fflags = 5'b00001.
- Fill and drain:
  - Stimulus: `out_ready_i`=0, push 3 groups with regindex 1, 2, 3.
  - Response: only 1 and 2 are accepted and `in_ready_o`=0. Raise `out_ready_i` and groups pop as 1 then 2; `in_ready_o`=1 in the cycle after the first pop.
- Streaming:
  - Stimulus: `in_valid_i` and `out_ready_i` held at 1 for 10 cycles with warpid 0..9.
  - Response: 10 outputs in order, count never exceeds 1, and no stall occurs.
- Simultaneous push and pop at count=1: count stays 1 and the pointers advance. The next output is the new group.
- Wrap with DEPTH=3: 7 groups pushed with random backpressure emerge in order with correct data.
- Reset mid-operation: assert `rst` with 2 entries held. The next cycle shows `out_valid_o`=0, `in_ready_o`=1, all outputs 0, and no stale group appears afterwards.
